// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS general-purpose register file.
package regfile_pkg;

   localparam int unsigned REG_DATA_W = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_COUNT  = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [REG_DATA_W-1:0] reg_word_t;

   localparam reg_idx_t ZERO_REG = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, same-cycle write bypass, $zero force.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W       = REG_DATA_W,
   parameter int unsigned ADDR_W       = REG_ADDR_W,
   parameter bit          WRITE_BYPASS = 1'b1
) (
   input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
   input  logic [ADDR_W-1:0] rd_idx_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] rd_data_c_o
);

   logic bypass_hit_c;

   // wr_en_i is already qualified with a nonzero write index by the caller.
   assign bypass_hit_c = WRITE_BYPASS && wr_en_i && (wr_idx_i == rd_idx_i);

   always_comb begin
      rd_data_c_o = regs_i[rd_idx_i];
      if (bypass_hit_c) begin
         rd_data_c_o = wr_data_i;
      end
      if (rd_idx_i == ADDR_W'(0)) begin
         rd_data_c_o = '0;
      end
   end

endmodule : regfile_read_port

// File: rtl/registers_32.sv
// MIPS register file: 32 x 32-bit, two combinational reads, one clocked write.
module registers_32
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W       = REG_DATA_W,
   parameter int unsigned ADDR_W       = REG_ADDR_W,
   parameter bit          WRITE_BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteRegData,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              wr_arm_q;
   logic              wr_en_c;

   // Writes are held off until the first edge that sees rst_n high,
   // so an edge coinciding with reset release never writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_arm_q <= 1'b0;
      end else begin
         wr_arm_q <= 1'b1;
      end
   end

   assign wr_en_c = RegWrite && wr_arm_q && (WriteReg != ADDR_W'(0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_c) begin
         regs_q[WriteReg] <= WriteRegData;
      end
   end

   regfile_read_port #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .WRITE_BYPASS (WRITE_BYPASS)
   ) u_rd_port1 (
      .regs_i      (regs_q),
      .rd_idx_i    (ReadReg1),
      .wr_en_i     (wr_en_c),
      .wr_idx_i    (WriteReg),
      .wr_data_i   (WriteRegData),
      .rd_data_c_o (ReadData1)
   );

   regfile_read_port #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .WRITE_BYPASS (WRITE_BYPASS)
   ) u_rd_port2 (
      .regs_i      (regs_q),
      .rd_idx_i    (ReadReg2),
      .wr_en_i     (wr_en_c),
      .wr_idx_i    (WriteReg),
      .wr_data_i   (WriteRegData),
      .rd_data_c_o (ReadData2)
   );

endmodule : registers_32

// File: tb/tb_registers_32.sv
// Directed bench for registers_32: reset, writes, $zero, bypass, reset pulse.
`timescale 1ns/1ps
module tb_registers_32;

   logic        clk;
   logic        rst_n;
   logic        RegWrite;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [4:0]  WriteReg;
   logic [31:0] WriteRegData;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;

   int checks;
   int errors;

   registers_32 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .RegWrite     (RegWrite),
      .ReadReg1     (ReadReg1),
      .ReadReg2     (ReadReg2),
      .WriteReg     (WriteReg),
      .WriteRegData (WriteRegData),
      .ReadData1    (ReadData1),
      .ReadData2    (ReadData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0; RegWrite = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
      WriteReg = 5'd0; WriteRegData = 32'h0;
      #12;
      for (int i = 1; i < 32; i += 10) begin
         ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
         #1;
         checks++;
         if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_read idx=%0d: got %h/%h expected 0/0", i, ReadData1, ReadData2);
         end
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_first_write();
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd3; WriteRegData = 32'd10;
      ReadReg1 = 5'd7; ReadReg2 = 5'd8;
      #1;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         errors++;
         $display("FAIL first_write_pre: got %h/%h expected 0/0", ReadData1, ReadData2);
      end
      @(posedge clk); #1;
      RegWrite = 1'b0; ReadReg1 = 5'd3;
      #1;
      checks++;
      if (ReadData1 !== 32'd10) begin
         errors++;
         $display("FAIL first_write_post: got %h expected %h", ReadData1, 32'd10);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd0; WriteRegData = 32'hDEADBEEF;
      ReadReg1 = 5'd0; ReadReg2 = 5'd0;
      #1;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         errors++;
         $display("FAIL zero_bypass: got %h/%h expected 0/0", ReadData1, ReadData2);
      end
      @(posedge clk); #1;
      RegWrite = 1'b0;
      #1;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         errors++;
         $display("FAIL zero_stored: got %h/%h expected 0/0", ReadData1, ReadData2);
      end
   endtask

   task automatic test_no_write();
      @(negedge clk);
      RegWrite = 1'b0; WriteReg = 5'd5; WriteRegData = 32'h1234;
      ReadReg1 = 5'd5; ReadReg2 = 5'd5;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         errors++;
         $display("FAIL no_write: got %h/%h expected 0/0", ReadData1, ReadData2);
      end
   endtask

   task automatic test_two_ports();
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd1; WriteRegData = 32'hA5A5A5A5;
      @(negedge clk);
      WriteReg = 5'd31; WriteRegData = 32'h5A5A5A5A;
      @(negedge clk);
      RegWrite = 1'b0; ReadReg1 = 5'd1; ReadReg2 = 5'd31;
      #1;
      checks++;
      if (ReadData1 !== 32'hA5A5A5A5 || ReadData2 !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL two_ports: got %h/%h expected a5a5a5a5/5a5a5a5a", ReadData1, ReadData2);
      end
      ReadReg1 = 5'd31;
      #1;
      checks++;
      if (ReadData1 !== 32'h5A5A5A5A || ReadData2 !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL same_reg: got %h/%h expected 5a5a5a5a/5a5a5a5a", ReadData1, ReadData2);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd9; WriteRegData = 32'h77;
      ReadReg1 = 5'd1; ReadReg2 = 5'd9;
      #1;
      checks++;
      if (ReadData2 !== 32'h77) begin
         errors++;
         $display("FAIL bypass_pre: got %h expected %h", ReadData2, 32'h77);
      end
      checks++;
      if (ReadData1 !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL bypass_other_port: got %h expected a5a5a5a5", ReadData1);
      end
      @(posedge clk); #1;
      RegWrite = 1'b0; WriteRegData = 32'hFFFF_0000;
      #1;
      checks++;
      if (ReadData2 !== 32'h77) begin
         errors++;
         $display("FAIL bypass_post: got %h expected %h", ReadData2, 32'h77);
      end
   endtask

   task automatic test_fill_and_reset_pulse();
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         RegWrite = 1'b1; WriteReg = 5'(i); WriteRegData = 32'(i * 3);
      end
      @(negedge clk);
      RegWrite = 1'b0;
      for (int i = 1; i < 32; i++) begin
         ReadReg1 = 5'(i); ReadReg2 = 5'(32 - i);
         #0.2;
         checks++;
         if (ReadData1 !== 32'(i * 3) || ReadData2 !== 32'((32 - i) * 3)) begin
            errors++;
            $display("FAIL fill idx=%0d: got %h/%h expected %h/%h",
                     i, ReadData1, ReadData2, 32'(i * 3), 32'((32 - i) * 3));
         end
      end
      // Pulse reset entirely within the low clock phase.
      @(negedge clk); #1;
      ReadReg1 = 5'd7; ReadReg2 = 5'd30;
      rst_n = 1'b0;
      #0.5;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         errors++;
         $display("FAIL pulse_immediate: got %h/%h expected 0/0", ReadData1, ReadData2);
      end
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i < 32; i++) begin
         ReadReg1 = 5'(i); ReadReg2 = 5'(i);
         #0.2;
         checks++;
         if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            errors++;
            $display("FAIL pulse_after idx=%0d: got %h/%h expected 0/0", i, ReadData1, ReadData2);
         end
      end
   endtask

   task automatic test_release_edge();
      @(negedge clk);
      rst_n = 1'b0;
      RegWrite = 1'b1; WriteReg = 5'd4; WriteRegData = 32'd44;
      ReadReg1 = 5'd4; ReadReg2 = 5'd4;
      #1;
      checks++;
      if (ReadData1 !== 32'h0) begin
         errors++;
         $display("FAIL reset_no_bypass: got %h expected 0", ReadData1);
      end
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      RegWrite = 1'b0;
      #1;
      checks++;
      if (ReadData1 !== 32'h0) begin
         errors++;
         $display("FAIL release_edge_write: got %h expected 0", ReadData1);
      end
      @(negedge clk);
      RegWrite = 1'b1; WriteRegData = 32'd55;
      @(posedge clk); #1;
      RegWrite = 1'b0;
      #1;
      checks++;
      if (ReadData2 !== 32'd55) begin
         errors++;
         $display("FAIL write_after_release: got %h expected %h", ReadData2, 32'd55);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_first_write();
      test_zero_reg();
      test_no_write();
      test_two_ports();
      test_bypass();
      test_fill_and_reset_pulse();
      test_release_edge();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_registers_32
